systolic_link: RTL
==================

SYSTOLIC_LINK -- requirements
Module: systolic_link

Interface
REQ-001 SHALL have parameter LANE_W, default 4: data bits per beat per direction.
REQ-002 SHALL have parameter FRAME_LEN, default 16: beats per frame; power of two, >=4; CNT_W = log2(FRAME_LEN).
REQ-003 SHALL have port clk  in  1: single clock; one clock, reset asynchronous and active-low.
REQ-004 SHALL have port rst_n  in  1: asynchronous active-low reset.
REQ-005 SHALL have port ena  in  1: beat enable; low freezes all state.
REQ-006 SHALL have port frame_sync  in  1: current input beat is beat 0.
REQ-007 SHALL have ports col_in, row_in  in  LANE_W; col_ctrl_in, row_ctrl_in  in  1: serial beat inputs.
REQ-008 SHALL have ports col_out, row_out  out  LANE_W; col_ctrl_out, row_ctrl_out  out  1: serial beat outputs.
REQ-009 SHALL have port beat  out  CNT_W: current beat index.
REQ-010 SHALL have ports cap_valid  out  1, cap_ready  in  1, cap_col, cap_row  out  LANE_W*FRAME_LEN, cap_col_ctrl, cap_row_ctrl  out  FRAME_LEN: captured-frame handshake; beat 0 in MSBs.
REQ-011 SHALL have ports inj_valid  in  1, inj_ready  out  1, inj_col, inj_row  in  LANE_W*FRAME_LEN, inj_col_ctrl, inj_row_ctrl  in  FRAME_LEN: frame injection handshake.
REQ-012 SHALL have ports cap_ovf, resync_err  out  1: sticky error flags.

Function
REQ-013 SHALL, on each posedge with ena=1, store inputs into receive buffer slot beat, then increment beat modulo FRAME_LEN.
REQ-014 SHALL, when frame_sync=1 with ena=1, store inputs as slot 0 and set beat to 1; if beat was nonzero, discard partial frame (no commit) and set resync_err.
REQ-015 SHALL commit a frame on the posedge where beat=FRAME_LEN-1 and frame_sync=0: all slots including the final beat copied to the transmit buffer.
REQ-016 SHALL, at commit with inj_valid=1, load transmit buffer from inj_* instead and pulse inj_ready for exactly that cycle; inj_ready=0 otherwise.
REQ-017 SHALL update all four serial outputs on the falling edge of clk with transmit slot beat; latency = exactly one frame (input beat k of frame n appears during beat k of frame n+1).
REQ-018 SHALL hold serial outputs, beat, and all buffers when ena=0.
REQ-019 SHALL, at commit, load cap_* with the received frame and set cap_valid=1 if cap_valid=0 or cap_ready=1; otherwise keep cap_* unchanged and set cap_ov, frame still forwarded.
REQ-020 SHALL clear cap_valid on cap_ready=1 when no commit occurs that cycle; cap_* SHALL be stable while cap_valid=1 and cap_ready=0.
REQ-021 SHALL, when commit and cap_ready coincide, transfer old frame and load new one with cap_valid remaining 1.
REQ-022 SHALL keep cap_ovf and resync_err set until reset.
REQ-023 SHALL wrap beat from FRAME_LEN-1 to 0 without gap cycles.

Reset
REQ-024 SHALL, while rst_n=0 (asynchronous), force beat=0, all buffers=0, serial outputs=0, cap_valid=0, inj_ready=0, cap_ovf=0, resync_err=0.
REQ-025 SHALL discard any partial frame on reset mid-frame; first post-reset frame outputs all zeros.

Structure
REQ-026 SHALL take default LANE_W, FRAME_LEN, and beat-index width constants from shared package systolic_pkg.
REQ-027 SHALL use one sub-module, systolic_beat_mux (parametrised FRAME_LEN-to-1, LANE_W+1 bits), per direction for transmit slot selection.

Verification
REQ-028 SHALL cover: reset, col_in=beat index 0..15 for two frames -> second frame col_out reads 0,1,..,F, first frame zeros.
REQ-029 SHALL cover: frame_sync at beat 7 -> resync_err=1, no cap_valid, beat=1 next cycle, next full frame committed normally.
REQ-030 SHALL cover: cap_ready=0 across two commits -> cap_ovf=1, cap_col holds first frame.
REQ-031 SHALL cover: commit and cap_ready same cycle -> cap_valid stays 1, cap_col equals new frame.
REQ-032 SHALL cover: inj_valid=1, inj_col=0xA5A5..., at commit -> inj_ready one-cycle pulse, next frame col_out = A,5,A,5,...
REQ-033 SHALL cover: ena low for 3 cycles mid-frame, then rst_n pulse at beat 9 -> outputs/beat frozen, then all zero asynchronously.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared constants and slot-packing helpers for the systolic beat link.
package systolic_pkg;

  localparam int LANE_W_DEF    = 4;
  localparam int FRAME_LEN_DEF = 16;
  localparam int CNT_W_DEF     = $clog2(FRAME_LEN_DEF);

  // Bit offset of a beat's lane within a packed frame word (beat 0 sits in the MSBs).
  function automatic int slot_lsb(input int slot, input int lane_w, input int frame_len);
    return (frame_len - 1 - slot) * lane_w;
  endfunction

  // Bit position of a beat's control flag within a packed control word.
  function automatic int slot_bit(input int slot, input int frame_len);
    return frame_len - 1 - slot;
  endfunction

endpackage

// File: rtl/systolic_beat_mux.sv
// Selects one beat slot out of a flattened transmit frame.
module systolic_beat_mux
  import systolic_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int W         = LANE_W_DEF + 1,
  localparam int CNT_W    = $clog2(FRAME_LEN)
) (
  input  logic [FRAME_LEN*W-1:0] slots,
  input  logic [CNT_W-1:0]       sel,
  output logic [W-1:0]           dout
);

  // Slot k occupies bits [k*W +: W] of the flattened input.
  always_comb begin
    dout = slots[int'(sel)*W +: W];
  end

endmodule

// File: rtl/systolic_link.sv
// Framed serial link: buffers one frame per direction, replays it one frame
// later on the falling edge, and exposes a captured-frame / injection handshake.
module systolic_link
  import systolic_pkg::*;
#(
  parameter int LANE_W    = LANE_W_DEF,
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  localparam int CNT_W    = $clog2(FRAME_LEN)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ena,
  input  logic                        frame_sync,
  input  logic [LANE_W-1:0]           col_in,
  input  logic [LANE_W-1:0]           row_in,
  input  logic                        col_ctrl_in,
  input  logic                        row_ctrl_in,
  output logic [LANE_W-1:0]           col_out,
  output logic [LANE_W-1:0]           row_out,
  output logic                        col_ctrl_out,
  output logic                        row_ctrl_out,
  output logic [CNT_W-1:0]            beat,
  output logic                        cap_valid,
  input  logic                        cap_ready,
  output logic [LANE_W*FRAME_LEN-1:0] cap_col,
  output logic [LANE_W*FRAME_LEN-1:0] cap_row,
  output logic [FRAME_LEN-1:0]        cap_col_ctrl,
  output logic [FRAME_LEN-1:0]        cap_row_ctrl,
  input  logic                        inj_valid,
  output logic                        inj_ready,
  input  logic [LANE_W*FRAME_LEN-1:0] inj_col,
  input  logic [LANE_W*FRAME_LEN-1:0] inj_row,
  input  logic [FRAME_LEN-1:0]        inj_col_ctrl,
  input  logic [FRAME_LEN-1:0]        inj_row_ctrl,
  output logic                        cap_ovf,
  output logic                        resync_err
);

  localparam int              MUX_W     = LANE_W + 1;
  localparam logic [CNT_W-1:0] BEAT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] BEAT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(FRAME_LEN - 1);

  logic [CNT_W-1:0]  beat_r;
  logic              resync_err_r;

  logic [LANE_W-1:0] rx_col_r [FRAME_LEN];
  logic [LANE_W-1:0] rx_row_r [FRAME_LEN];
  logic [FRAME_LEN-1:0] rx_col_ctrl_r;
  logic [FRAME_LEN-1:0] rx_row_ctrl_r;

  logic [LANE_W-1:0] tx_col_r [FRAME_LEN];
  logic [LANE_W-1:0] tx_row_r [FRAME_LEN];
  logic [FRAME_LEN-1:0] tx_col_ctrl_r;
  logic [FRAME_LEN-1:0] tx_row_ctrl_r;

  logic [LANE_W-1:0] frame_col_s [FRAME_LEN];
  logic [LANE_W-1:0] frame_row_s [FRAME_LEN];
  logic [FRAME_LEN-1:0] frame_col_ctrl_s;
  logic [FRAME_LEN-1:0] frame_row_ctrl_s;

  logic              commit_s;
  logic [CNT_W-1:0]  wr_slot_s;

  logic [FRAME_LEN*MUX_W-1:0] col_slots_s;
  logic [FRAME_LEN*MUX_W-1:0] row_slots_s;
  logic [MUX_W-1:0]           col_sel_s;
  logic [MUX_W-1:0]           row_sel_s;

  logic [LANE_W-1:0] col_out_r;
  logic [LANE_W-1:0] row_out_r;
  logic              col_ctrl_out_r;
  logic              row_ctrl_out_r;

  logic                        cap_valid_r;
  logic                        cap_ovf_r;
  logic [LANE_W*FRAME_LEN-1:0] cap_col_r;
  logic [LANE_W*FRAME_LEN-1:0] cap_row_r;
  logic [FRAME_LEN-1:0]        cap_col_ctrl_r;
  logic [FRAME_LEN-1:0]        cap_row_ctrl_r;

  // Commit fires on the last beat unless a sync restarts the frame; sync always writes slot 0.
  always_comb begin
    commit_s  = ena & ~frame_sync & (beat_r == BEAT_LAST);
    inj_ready = commit_s & inj_valid;
    if (frame_sync) begin
      wr_slot_s = BEAT_ZERO;
    end else begin
      wr_slot_s = beat_r;
    end
  end

  // The committed frame is the receive buffer with the final beat taken straight from the inputs.
  always_comb begin
    frame_col_ctrl_s = rx_col_ctrl_r;
    frame_row_ctrl_s = rx_row_ctrl_r;
    for (int k = 0; k < FRAME_LEN; k++) begin
      frame_col_s[k] = rx_col_r[k];
      frame_row_s[k] = rx_row_r[k];
    end
    frame_col_s[FRAME_LEN-1]      = col_in;
    frame_row_s[FRAME_LEN-1]      = row_in;
    frame_col_ctrl_s[FRAME_LEN-1] = col_ctrl_in;
    frame_row_ctrl_s[FRAME_LEN-1] = row_ctrl_in;
  end

  // Beat counter and sticky resync flag; a sync mid-frame abandons the partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_r       <= BEAT_ZERO;
      resync_err_r <= 1'b0;
    end else if (ena) begin
      if (frame_sync) begin
        beat_r <= BEAT_ONE;
        if (beat_r != BEAT_ZERO) begin
          resync_err_r <= 1'b1;
        end
      end else begin
        beat_r <= beat_r + BEAT_ONE;
      end
    end
  end

  // Receive buffer: each enabled beat lands in its slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_col_ctrl_r <= '0;
      rx_row_ctrl_r <= '0;
      for (int k = 0; k < FRAME_LEN; k++) begin
        rx_col_r[k] <= '0;
        rx_row_r[k] <= '0;
      end
    end else if (ena) begin
      rx_col_r[wr_slot_s]      <= col_in;
      rx_row_r[wr_slot_s]      <= row_in;
      rx_col_ctrl_r[wr_slot_s] <= col_ctrl_in;
      rx_row_ctrl_r[wr_slot_s] <= row_ctrl_in;
    end
  end

  // Transmit buffer: reloaded at commit from the received frame or from the injection port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_col_ctrl_r <= '0;
      tx_row_ctrl_r <= '0;
      for (int k = 0; k < FRAME_LEN; k++) begin
        tx_col_r[k] <= '0;
        tx_row_r[k] <= '0;
      end
    end else if (commit_s) begin
      for (int k = 0; k < FRAME_LEN; k++) begin
        if (inj_valid) begin
          tx_col_r[k]      <= inj_col[slot_lsb(k, LANE_W, FRAME_LEN) +: LANE_W];
          tx_row_r[k]      <= inj_row[slot_lsb(k, LANE_W, FRAME_LEN) +: LANE_W];
          tx_col_ctrl_r[k] <= inj_col_ctrl[slot_bit(k, FRAME_LEN)];
          tx_row_ctrl_r[k] <= inj_row_ctrl[slot_bit(k, FRAME_LEN)];
        end else begin
          tx_col_r[k]      <= frame_col_s[k];
          tx_row_r[k]      <= frame_row_s[k];
          tx_col_ctrl_r[k] <= frame_col_ctrl_s[k];
          tx_row_ctrl_r[k] <= frame_row_ctrl_s[k];
        end
      end
    end
  end

  // Flatten the transmit slots as {ctrl, data} per beat for the slot selectors.
  always_comb begin
    col_slots_s = '0;
    row_slots_s = '0;
    for (int k = 0; k < FRAME_LEN; k++) begin
      col_slots_s[k*MUX_W +: MUX_W] = {tx_col_ctrl_r[k], tx_col_r[k]};
      row_slots_s[k*MUX_W +: MUX_W] = {tx_row_ctrl_r[k], tx_row_r[k]};
    end
  end

  systolic_beat_mux #(
    .FRAME_LEN (FRAME_LEN),
    .W         (MUX_W)
  ) u_col_mux (
    .slots (col_slots_s),
    .sel   (beat_r),
    .dout  (col_sel_s)
  );

  systolic_beat_mux #(
    .FRAME_LEN (FRAME_LEN),
    .W         (MUX_W)
  ) u_row_mux (
    .slots (row_slots_s),
    .sel   (beat_r),
    .dout  (row_sel_s)
  );

  // Serial outputs launch on the falling edge; with ena low beat and tx are frozen, so they hold.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_out_r      <= '0;
      row_out_r      <= '0;
      col_ctrl_out_r <= 1'b0;
      row_ctrl_out_r <= 1'b0;
    end else begin
      col_out_r      <= col_sel_s[LANE_W-1:0];
      row_out_r      <= row_sel_s[LANE_W-1:0];
      col_ctrl_out_r <= col_sel_s[LANE_W];
      row_ctrl_out_r <= row_sel_s[LANE_W];
    end
  end

  // Capture port: load on commit when free or being drained, else flag overflow and keep the old frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_valid_r    <= 1'b0;
      cap_ovf_r      <= 1'b0;
      cap_col_r      <= '0;
      cap_row_r      <= '0;
      cap_col_ctrl_r <= '0;
      cap_row_ctrl_r <= '0;
    end else if (commit_s) begin
      if (!cap_valid_r || cap_ready) begin
        cap_valid_r <= 1'b1;
        for (int k = 0; k < FRAME_LEN; k++) begin
          cap_col_r[slot_lsb(k, LANE_W, FRAME_LEN) +: LANE_W] <= frame_col_s[k];
          cap_row_r[slot_lsb(k, LANE_W, FRAME_LEN) +: LANE_W] <= frame_row_s[k];
          cap_col_ctrl_r[slot_bit(k, FRAME_LEN)]              <= frame_col_ctrl_s[k];
          cap_row_ctrl_r[slot_bit(k, FRAME_LEN)]              <= frame_row_ctrl_s[k];
        end
      end else begin
        cap_ovf_r <= 1'b1;
      end
    end else if (ena && cap_ready) begin
      cap_valid_r <= 1'b0;
    end
  end

  assign beat         = beat_r;
  assign resync_err   = resync_err_r;
  assign col_out      = col_out_r;
  assign row_out      = row_out_r;
  assign col_ctrl_out = col_ctrl_out_r;
  assign row_ctrl_out = row_ctrl_out_r;
  assign cap_valid    = cap_valid_r;
  assign cap_ovf      = cap_ovf_r;
  assign cap_col      = cap_col_r;
  assign cap_row      = cap_row_r;
  assign cap_col_ctrl = cap_col_ctrl_r;
  assign cap_row_ctrl = cap_row_ctrl_r;

endmodule
